// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: latches a, b and cin on start, then adds one bit per clock, LSB first.
// The result is transferred to S/C on the last add edge, and done pulses for one cycle.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic             carry_q, carry_d, c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       fa_s;
  logic [WIDTH:0]   shift_s;
  logic             last_s;

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Two half adders plus an OR of their carries; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], ci);
    return {h0[1] | h1[1], h1[0]};
  endfunction

  assign fa_s    = full_add(a_q[0], b_q[0], carry_q);
  assign shift_s = {fa_s[0], res_q};
  assign last_s  = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ADD:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values: operand shift registers, running carry, counter, result
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          a_d     = a_q;
          b_d     = b_q;
          carry_d = carry_q;
        end
      end
      ADD: begin
        res_d   = shift_s[WIDTH:1];
        carry_d = fa_s[1];
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        // The last bit lands in res_d this edge, so S takes the fully shifted value.
        if (last_s) begin
          s_d = shift_s[WIDTH:1];
          c_d = fa_s[1];
        end else begin
          s_d = s_q;
          c_d = c_q;
        end
      end
      default: begin
        s_d = s_q;
        c_d = c_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  assign S = s_q;
  assign C = c_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances) against
// an arithmetic reference: {C,S} = a + b + cin, done W+1 cycles after the start cycle.
module tb_serial_adder_ctrl;

  localparam int W8 = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       s8, s1;
  logic [7:0] a8, b8;
  logic       c8;
  logic [0:0] a1, b1;
  logic       c1;
  logic       busy8, done8, C8;
  logic [7:0] S8;
  logic       busy1, done1, C1;
  logic [0:0] S1;

  int          vecs = 0;
  int          errs = 0;
  logic [63:0] prev8 = 64'd0;
  logic [63:0] prev1 = 64'd0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .S(S8), .C(C8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .S(S1), .C(C1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the chosen instance; operands are scrambled right after acceptance.
  task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [63:0] mask, sum, sv, cv, pv;
    logic        bz, dn, got;
    int          busy_n;
    mask = (64'd1 << w) - 64'd1;
    sum  = (64'(a) & mask) + (64'(b) & mask) + 64'(ci);
    pv   = (w == 8) ? prev8 : prev1;
    @(negedge clk);
    if (w == 8) begin
      a8 = a; b8 = b; c8 = ci; s8 = 1'b1;
    end else begin
      a1 = a[0:0]; b1 = b[0:0]; c1 = ci; s1 = 1'b1;
    end
    @(posedge clk);
    #1;
    s8 = 1'b0; s1 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
    busy_n = 0;
    got    = 1'b0;
    for (int i = 1; i <= w + 4 && !got; i++) begin
      @(negedge clk);
      bz = (w == 8) ? busy8 : busy1;
      dn = (w == 8) ? done8 : done1;
      sv = (w == 8) ? 64'(S8) : 64'(S1);
      cv = (w == 8) ? 64'(C8) : 64'(C1);
      check("busy_done_excl", 64'(bz & dn), 64'd0);
      if (bz) begin
        busy_n++;
        check("s_hold_in_add", sv, pv);
      end
      if (dn) begin
        got = 1'b1;
        check("done_latency", 64'(i), 64'(w + 1));
        check("sum", sv, sum & mask);
        check("carry", cv, (sum >> w) & 64'd1);
      end
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
    check("busy_len", 64'(busy_n), 64'(w));
    @(negedge clk);
    check("done_pulse_width", 64'((w == 8) ? done8 : done1), 64'd0);
    if (w == 8) prev8 = sum & mask;
    else        prev1 = sum & mask;
  endtask

  initial begin
    logic [63:0] q[$];
    logic [63:0] e;
    int          wait_n, last, ndone, nacc;

    rst = 1'b1;
    s8 = 1'b0; s1 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    #2;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_s8", 64'(S8), 64'd0);
    check("rst_c8", 64'(C8), 64'd0);
    check("rst_busy1_done1", 64'({busy1, done1, S1, C1}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    op(8, 8'h03, 8'h05, 1'b0);
    op(8, 8'hFF, 8'h01, 1'b0);
    op(8, 8'hFF, 8'hFF, 1'b1);
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        op(1, 8'(x), 8'(y), 1'b0);
      end
    end

    // Start held high with operands changing every cycle; accepts every W8+2 edges.
    wait_n = 0; last = -1; ndone = 0; nacc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("cont_excl", 64'(busy8 & done8), 64'd0);
      if (done8) begin
        ndone++;
        if (q.size() == 0) begin
          check("cont_spurious_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("cont_sum", 64'({C8, S8}), e);
          prev8 = e & 64'hFF;
        end
        if (last >= 0) check("cont_period", 64'(i - last), 64'(W8 + 2));
        last = i;
      end
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); s8 = 1'b1;
      if (wait_n == 0) begin
        q.push_back(64'(a8) + 64'(b8) + 64'(c8));
        wait_n = W8 + 1;
        nacc++;
      end else begin
        wait_n--;
      end
    end
    @(posedge clk);
    #1;
    s8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (q.size() == 0) begin
          check("cont_spurious_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("cont_sum", 64'({C8, S8}), e);
          prev8 = e & 64'hFF;
        end
      end
    end
    check("cont_count", 64'(ndone), 64'(nacc));

    // Asynchronous reset during bit 4 of an addition.
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; c8 = 1'b0; s8 = 1'b1;
    @(posedge clk);
    #1;
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_outputs", 64'({busy8, done8, C8, S8}), 64'd0);
    prev8 = 64'd0;
    #4;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("arst_no_done", 64'({busy8, done8}), 64'd0);
    end
    op(8, 8'h10, 8'h20, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      op(8, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
